// File: rtl/musb_mem_arbiter.sv
// rtl/musb_mem_arbiter.sv - two-master round-robin memory arbiter with bus watchdog
// Shares one memory port between the core iport and dport; one transaction at a time.
module musb_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] iport_address,
  input  logic                  iport_enable,
  output logic [31:0]           iport_data_o,
  output logic                  iport_ready,
  output logic                  iport_error,
  input  logic [ADDR_WIDTH-1:0] dport_address,
  input  logic [31:0]           dport_data_i,
  input  logic [3:0]            dport_wr,
  input  logic                  dport_enable,
  output logic [31:0]           dport_data_o,
  output logic                  dport_ready,
  output logic                  dport_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_o,
  output logic [3:0]            mem_wr,
  output logic                  mem_enable,
  input  logic [31:0]           mem_data_i,
  input  logic                  mem_ready,
  input  logic                  mem_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam bit                WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic                last_grant;   // 1: dport was granted last
  logic [TO_WIDTH-1:0] wd_count;
  logic                grant_i;
  logic                grant_d;
  logic                busy;
  logic                timeout;
  logic                finish;
  logic                success;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    busy       = (state == BUSY_I) || (state == BUSY_D);
    timeout    = WD_EN && (wd_count == TO_LAST);
    finish     = busy && (mem_ready || mem_error || timeout);
    success    = mem_ready && !mem_error;
    case (state)
      IDLE: begin
        if (iport_enable && dport_enable) begin
          grant_i = last_grant;
          grant_d = !last_grant;
        end else begin
          grant_i = iport_enable;
          grant_d = dport_enable;
        end
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      wd_count   <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        last_grant <= 1'b1;
      end else if (grant_i) begin
        last_grant <= 1'b0;
      end
      if (busy) begin
        wd_count <= wd_count + 1'b1;
      end else begin
        wd_count <= '0;
      end
    end
  end

  // Request is latched at grant so the master may change or drop its inputs afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_address <= '0;
      mem_data_o  <= '0;
      mem_wr      <= '0;
      mem_enable  <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_address <= dport_address;
        mem_data_o  <= dport_data_i;
        mem_wr      <= dport_wr;
        mem_enable  <= 1'b1;
      end else if (grant_i) begin
        mem_address <= iport_address;
        mem_data_o  <= '0;
        mem_wr      <= '0;
        mem_enable  <= 1'b1;
      end else if (finish) begin
        mem_enable  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iport_data_o <= '0;
      iport_ready  <= 1'b0;
      iport_error  <= 1'b0;
      dport_data_o <= '0;
      dport_ready  <= 1'b0;
      dport_error  <= 1'b0;
    end else begin
      iport_ready <= 1'b0;
      iport_error <= 1'b0;
      dport_ready <= 1'b0;
      dport_error <= 1'b0;
      if (finish) begin
        if (state == BUSY_D) begin
          if (success) begin
            dport_ready  <= 1'b1;
            dport_data_o <= mem_data_i;
          end else begin
            dport_error  <= 1'b1;
          end
        end else begin
          if (success) begin
            iport_ready  <= 1'b1;
            iport_data_o <= mem_data_i;
          end else begin
            iport_error  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_musb_mem_arbiter.sv
// tb/tb_musb_mem_arbiter.sv - scoreboard bench for musb_mem_arbiter
`timescale 1ns/1ps
module tb_musb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] iport_address = '0;
  logic        iport_enable = 1'b0;
  logic [31:0] iport_data_o;
  logic        iport_ready, iport_error;
  logic [31:0] dport_address = '0;
  logic [31:0] dport_data_i = '0;
  logic [3:0]  dport_wr = '0;
  logic        dport_enable = 1'b0;
  logic [31:0] dport_data_o;
  logic        dport_ready, dport_error;
  logic [31:0] mem_address, mem_data_o;
  logic [3:0]  mem_wr;
  logic        mem_enable;
  logic [31:0] mem_data_i = '0;
  logic        mem_ready = 1'b0;
  logic        mem_error = 1'b0;

  logic [31:0] z_iport_address = '0;
  logic        z_iport_enable = 1'b0;
  logic [31:0] z_iport_data_o;
  logic        z_iport_ready, z_iport_error;
  logic [31:0] z_dport_data_o;
  logic        z_dport_ready, z_dport_error;
  logic [31:0] z_mem_address, z_mem_data_o;
  logic [3:0]  z_mem_wr;
  logic        z_mem_enable;
  logic [31:0] z_mem_data_i = '0;
  logic        z_mem_ready = 1'b0;
  logic        z_err_seen = 1'b0;

  musb_mem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8), .TO_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .iport_address(iport_address), .iport_enable(iport_enable),
    .iport_data_o(iport_data_o), .iport_ready(iport_ready), .iport_error(iport_error),
    .dport_address(dport_address), .dport_data_i(dport_data_i), .dport_wr(dport_wr),
    .dport_enable(dport_enable), .dport_data_o(dport_data_o),
    .dport_ready(dport_ready), .dport_error(dport_error),
    .mem_address(mem_address), .mem_data_o(mem_data_o), .mem_wr(mem_wr),
    .mem_enable(mem_enable), .mem_data_i(mem_data_i),
    .mem_ready(mem_ready), .mem_error(mem_error)
  );

  musb_mem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0), .TO_WIDTH(8)) u_dut_nowd (
    .clk(clk), .rst(rst),
    .iport_address(z_iport_address), .iport_enable(z_iport_enable),
    .iport_data_o(z_iport_data_o), .iport_ready(z_iport_ready), .iport_error(z_iport_error),
    .dport_address('0), .dport_data_i('0), .dport_wr('0),
    .dport_enable(1'b0), .dport_data_o(z_dport_data_o),
    .dport_ready(z_dport_ready), .dport_error(z_dport_error),
    .mem_address(z_mem_address), .mem_data_o(z_mem_data_o), .mem_wr(z_mem_wr),
    .mem_enable(z_mem_enable), .mem_data_i(z_mem_data_i),
    .mem_ready(z_mem_ready), .mem_error(1'b0)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wr;
  } gnt_t;

  typedef struct packed {
    logic        is_d;
    logic        is_err;
    logic [31:0] data;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  gnt_t cur_g = '0;
  logic prev_en = 1'b0;
  logic prev_rsp = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (z_iport_error) z_err_seen <= 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: grants and responses are popped from the queues as the DUT presents them.
  always @(negedge clk) begin
    logic any;
    any = iport_ready | iport_error | dport_ready | dport_error;
    if (mem_enable && !prev_en) begin
      if (gnt_q.size() == 0) begin
        fail("unexpected_grant");
      end else begin
        cur_g = gnt_q.pop_front();
        chk("grant_addr", mem_address, cur_g.addr);
        chk("grant_data", mem_data_o, cur_g.data);
        chk("grant_wr", {28'd0, mem_wr}, {28'd0, cur_g.wr});
      end
    end else if (mem_enable) begin
      chk("hold_addr", mem_address, cur_g.addr);
      chk("hold_data", mem_data_o, cur_g.data);
      chk("hold_wr", {28'd0, mem_wr}, {28'd0, cur_g.wr});
    end
    if (any) begin
      chk("resp_onehot", $countones({iport_ready, iport_error, dport_ready, dport_error}), 1);
      chk("resp_pulse_width", {31'd0, prev_rsp}, 0);
      if (rsp_q.size() == 0) begin
        fail("unexpected_resp");
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("resp_port", {31'd0, dport_ready | dport_error}, {31'd0, r.is_d});
        chk("resp_kind", {31'd0, iport_error | dport_error}, {31'd0, r.is_err});
        chk("resp_data", r.is_d ? dport_data_o : iport_data_o, r.data);
      end
    end
    prev_en  <= mem_enable;
    prev_rsp <= any;
  end

  task automatic drop_enables();
    iport_enable = 1'b0;
    dport_enable = 1'b0;
  endtask

  task automatic run_txn(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wr, input int lat, input bit rdy, input bit err,
                         input logic [31:0] rdata, input bit exp_err,
                         input logic [31:0] exp_data, input int exp_wd);
    int t_req;
    int n;
    logic flag;
    @(posedge clk); #1;
    if (is_d) begin
      dport_address = addr; dport_data_i = wdata; dport_wr = wr; dport_enable = 1'b1;
    end else begin
      iport_address = addr; iport_enable = 1'b1;
    end
    t_req = cyc;
    gnt_q.push_back(gnt_t'{addr: addr, data: is_d ? wdata : 32'd0, wr: is_d ? wr : 4'd0});
    rsp_q.push_back(rsp_t'{is_d: is_d, is_err: exp_err, data: exp_data});
    n = 0;
    @(negedge clk);
    while (!mem_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_enable) begin
      fail("grant_wait_expired");
      drop_enables();
      return;
    end
    chk("grant_latency", cyc - t_req, 1);
    repeat (lat) @(negedge clk);
    if (rdy || err) begin
      mem_ready = rdy; mem_error = err; mem_data_i = rdata;
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_error = 1'b0; mem_data_i = '0;
      drop_enables();
      @(negedge clk);
      chk("resp_latency", cyc - t_req, 2 + lat);
    end else begin
      n = 1;
      @(negedge clk);
      while (mem_enable && n < 300) begin
        n++;
        @(negedge clk);
      end
      chk("watchdog_cycles", n, exp_wd);
      chk("resp_latency", cyc - t_req, 1 + exp_wd);
    end
    flag = is_d ? (exp_err ? dport_error : dport_ready) : (exp_err ? iport_error : iport_ready);
    chk("resp_timing", {31'd0, flag}, 1);
    if (!(rdy || err)) begin
      @(posedge clk); #1;
      drop_enables();
    end
  endtask

  // Both masters held high: grants alternate starting with the port not granted last.
  task automatic run_rr(input int rounds, input logic [31:0] base, input bit first_d);
    int t0;
    int n;
    bit d;
    @(posedge clk); #1;
    dport_address = 32'h300; dport_data_i = 32'h11110000; dport_wr = 4'h0;
    iport_address = 32'h400;
    dport_enable = 1'b1; iport_enable = 1'b1;
    t0 = cyc;
    for (int k = 0; k < rounds; k++) begin
      d = first_d ^ k[0];
      gnt_q.push_back(gnt_t'{addr: d ? 32'h300 : 32'h400, data: d ? 32'h11110000 : 32'd0, wr: 4'd0});
      rsp_q.push_back(rsp_t'{is_d: d, is_err: 1'b0, data: base + k});
    end
    for (int k = 0; k < rounds; k++) begin
      n = 0;
      @(negedge clk);
      while (!mem_enable && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!mem_enable) begin
        fail("rr_grant_wait_expired");
        break;
      end
      chk("rr_grant_cycle", cyc - t0, 1 + 3 * k);
      mem_ready = 1'b1; mem_data_i = base + k;
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_data_i = '0;
      if (k == rounds - 1) drop_enables();
    end
    drop_enables();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_mem_enable", {31'd0, mem_enable}, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_iport_data", iport_data_o, 0);
    chk("reset_dport_data", dport_data_o, 0);
    chk("reset_pulses", {28'd0, iport_ready, iport_error, dport_ready, dport_error}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_rr(4, 32'hA0, 1'b1);
    run_txn(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 0);
    run_txn(1'b1, 32'h200, 32'h12345678, 4'hF, 3, 1'b1, 1'b0, 32'hA2, 1'b0, 32'hA2, 0);
    run_txn(1'b1, 32'h204, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 0);
    run_txn(1'b1, 32'h208, 32'h0, 4'h0, 0, 1'b1, 1'b1, 32'h99999999, 1'b1, 32'hCAFEF00D, 0);
    run_txn(1'b0, 32'h10C, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 8);

    // Asynchronous reset in the middle of a dport store.
    @(posedge clk); #1;
    dport_address = 32'h500; dport_data_i = 32'h77; dport_wr = 4'hF; dport_enable = 1'b1;
    gnt_q.push_back(gnt_t'{addr: 32'h500, data: 32'h77, wr: 4'hF});
    n = 0;
    @(negedge clk);
    while (!mem_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_busy", {31'd0, mem_enable}, 1);
    #2;
    rst = 1'b0;
    dport_enable = 1'b0;
    #1;
    chk("async_reset_mem_enable", {31'd0, mem_enable}, 0);
    chk("async_reset_mem_address", mem_address, 0);
    chk("async_reset_mem_data", mem_data_o, 0);
    chk("async_reset_mem_wr", {28'd0, mem_wr}, 0);
    chk("async_reset_iport_data", iport_data_o, 0);
    chk("async_reset_dport_data", dport_data_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_rr(2, 32'hB0, 1'b1);

    // Watchdog disabled: the request waits far past any timeout.
    @(posedge clk); #1;
    z_iport_address = 32'h600; z_iport_enable = 1'b1;
    repeat (40) @(negedge clk);
    chk("nowd_enable_held", {31'd0, z_mem_enable}, 1);
    chk("nowd_no_error", {31'd0, z_err_seen}, 0);
    z_mem_ready = 1'b1; z_mem_data_i = 32'h0D0D0D0D;
    @(posedge clk); #1;
    z_mem_ready = 1'b0; z_iport_enable = 1'b0;
    @(negedge clk);
    chk("nowd_ready", {31'd0, z_iport_ready}, 1);
    chk("nowd_data", z_iport_data_o, 32'h0D0D0D0D);

    repeat (3) @(negedge clk);
    chk("grant_queue_drained", gnt_q.size(), 0);
    chk("resp_queue_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/musb_mem_arbiter.md
Name: musb_mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the single-port SoC memory between the core instruction port (iport) and data port (dport). Requests are serviced one at a time with round-robin priority. Granted requests are latched and presented to memory. A bus watchdog aborts stalled transactions with an error. The block sits in musoc between musb_core and the memory/bus slave.

Parameters:
ADDR_WIDTH, 32, width of address ports.
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ready before abort; 0 disables the watchdog.
TO_WIDTH, 8, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^TO_WIDTH.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-low reset.
iport_address  in  ADDR_WIDTH  instruction fetch address.
iport_enable  in  1  instruction read request; level, held until ready or error.
iport_data_o  out  32  fetched word.
iport_ready  out  1  one-cycle completion pulse.
iport_error  out  1  one-cycle error pulse.
dport_address  in  ADDR_WIDTH  data address.
dport_data_i  in  32  store data.
dport_wr  in  4  byte write enables; 0000 means read.
dport_enable  in  1  data request; level, held until ready or error.
dport_data_o  out  32  load data.
dport_ready  out  1  one-cycle completion pulse.
dport_error  out  1  one-cycle error pulse.
mem_address  out  ADDR_WIDTH  to memory.
mem_data_o  out  32  store data to memory.
mem_wr  out  4  byte enables to memory.
mem_enable  out  1  memory request.
mem_data_i  in  32  read data from memory.
mem_ready  in  1  memory completion.
mem_error  in  1  memory error; treated as a completion with error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=I. All outputs are 0, including data_o registers and the watchdog counter.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, one request: a sole iport_enable goes to BUSY_I; a sole dport_enable goes to BUSY_D.
- IDLE, both requests: the port not equal to last_grant wins. After reset, D wins a tie first.
- Grant: on the transition, latch address, data and wr of the winner into mem_* registers. Set mem_enable=1 and update last_grant. iport grants drive mem_wr=0000 and mem_data_o=0.
- BUSY_x: mem_* are held stable while mem_enable=1. The watchdog increments each BUSY cycle.
- BUSY_x, completion (mem_ready=1 or mem_error=1):
  - go to RESP and clear mem_enable;
  - on mem_ready with mem_error=0, capture mem_data_i into x_data_o;
  - next cycle pulse x_ready if mem_error=0, else pulse x_error;
  - mem_error has priority over mem_ready when both are high.
- BUSY_x, timeout: when the watchdog reaches TIMEOUT_CYCLES with no completion (and TIMEOUT_CYCLES≠0), go to RESP and clear mem_enable. x_error then pulses; x_data_o keeps its old value.
- RESP: the ready/error pulse is high for exactly this cycle. No requests are sampled here; a master's enable still high in RESP is ignored. Go to IDLE; the watchdog clears.
- Latency: request seen in IDLE at cycle N → mem_enable=1 at N+1. mem_ready at cycle M → x_ready=1 at M+1. Minimum request-to-ready is 2 cycles. Back-to-back service: one IDLE cycle between transactions.
- Outputs are registered; no combinational path from mem_* inputs to port outputs.
- A master dropping enable mid-transaction does not abort the transaction; the response pulse is still generated.
- x_data_o holds its value until the next successful read on that port.
- The non-granted port never sees ready or error.

Test Plan:
1. Reset: drive rst=0 mid-BUSY_D with mem_enable=1 → all outputs 0 immediately (asynchronous). After release, a tie grants D first.
2. Single iport read: iport_address=0x100, memory returns 0xDEADBEEF with mem_ready one cycle after mem_enable → mem_enable at N+1, iport_ready and iport_data_o=0xDEADBEEF at N+2, mem_wr=0000.
3. Store: dport_wr=1111, dport_data_i=0x12345678, address 0x200 → mem_wr=1111 and mem_data_o=0x12345678 held stable across 3 wait cycles; a single dport_ready pulse follows.
4. Round robin: both enables held continuously for 4 transactions → grant order D, I, D, I. Each ready pulse goes only to the granted port, with one IDLE gap between transactions.
5. Watchdog: TIMEOUT_CYCLES=8, mem_ready never asserts → after 8 BUSY cycles mem_enable drops and iport_error pulses for one cycle. iport_data_o is unchanged. With TIMEOUT_CYCLES=0 the arbiter waits indefinitely.
6. mem_error and mem_ready asserted together on a dport read → dport_error pulses, dport_ready stays 0, dport_data_o is unchanged.
